// File: rtl/vga_pkg.sv
// Shared VGA timing constants and helpers, used by the timing generator and the renderer.
// Latency: n/a (constants only).
// Backpressure: n/a.
package vga_pkg;

    // Total span of one axis: active region plus porches and sync.
    function automatic int vga_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    // 640x480 @ 60 Hz industry timing.
    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;

    localparam int VGA_H_TOTAL  = vga_total(VGA_H_ACTIVE, VGA_H_FP, VGA_H_SYNC, VGA_H_BP);
    localparam int VGA_V_TOTAL  = vga_total(VGA_V_ACTIVE, VGA_V_FP, VGA_V_SYNC, VGA_V_BP);

    // This mode uses negative-going sync pulses.
    localparam logic VGA_SYNC_ACTIVE = 1'b0;
    localparam int   VGA_FRAME_BITS  = 5;

endpackage

// File: rtl/vga_timing_if.sv
// Raster position and sync bundle between the timing generator and its consumers.
// Latency: n/a (wires only).
// Backpressure: none; en is a pixel-rate strobe driven by the consumer side.
interface vga_timing_if import vga_pkg::*; #(
    parameter int XB = $clog2(VGA_H_TOTAL),
    parameter int YB = $clog2(VGA_V_TOTAL),
    parameter int FB = VGA_FRAME_BITS
);
    logic          en;
    logic [XB-1:0] pixel_x;
    logic [YB-1:0] pixel_y;
    logic          hsync;
    logic          vsync;
    logic          de;
    logic          line_start;
    logic          frame_start;
    logic [FB-1:0] frame_count;

    modport master (
        input  en,
        output pixel_x, pixel_y, hsync, vsync, de, line_start, frame_start, frame_count
    );

    modport slave (
        output en,
        input  pixel_x, pixel_y, hsync, vsync, de, line_start, frame_start, frame_count
    );
endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter plus sync/active window compares on its next value.
// Latency: cnt is registered; *_nxt flags describe the position cnt will hold after this edge.
// Backpressure: none; the counter only moves on cycles with step=1.
module vga_axis_counter import vga_pkg::*; #(
    parameter int ACTIVE = VGA_H_ACTIVE,
    parameter int FP     = VGA_H_FP,
    parameter int SYNC   = VGA_H_SYNC,
    parameter int BP     = VGA_H_BP,
    parameter int W      = $clog2(vga_total(ACTIVE, FP, SYNC, BP))
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         step,
    output logic [W-1:0] cnt,
    output logic         wrap,
    output logic         sync_nxt,
    output logic         active_nxt,
    output logic         zero_nxt
);
    localparam int TOTAL = vga_total(ACTIVE, FP, SYNC, BP);

    // Compares run one bit wider so a window edge equal to a power of two still fits.
    localparam logic [W:0] LAST    = (W+1)'(TOTAL - 1);
    localparam logic [W:0] SYNC_LO = (W+1)'(ACTIVE + FP);
    localparam logic [W:0] SYNC_HI = (W+1)'(ACTIVE + FP + SYNC);
    localparam logic [W:0] ACT_HI  = (W+1)'(ACTIVE);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Advance on step, wrapping at the last position; wrap tells the next axis to move.
    always_comb begin
        cnt_d = cnt_q;
        wrap  = 1'b0;
        if (step) begin
            if ({1'b0, cnt_q} == LAST) begin
                cnt_d = '0;
                wrap  = 1'b1;
            end else begin
                cnt_d = cnt_q + W'(1);
            end
        end
    end

    // Position register; reset returns to the first pixel/line.
    always_ff @(posedge clk) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    // Window flags for the upcoming position so the caller can register them alongside cnt.
    always_comb begin
        sync_nxt   = ({1'b0, cnt_d} >= SYNC_LO) && ({1'b0, cnt_d} < SYNC_HI);
        active_nxt = ({1'b0, cnt_d} < ACT_HI);
        zero_nxt   = (cnt_d == '0);
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/vga_timing.sv
// VGA raster timing generator: pixel/line counters, sync, display enable and frame counter.
// Latency: all outputs registered and aligned to pixel_x/pixel_y; VGA_TIMING_PIPE_EN delays hsync/vsync/de by one en cycle.
// Backpressure: none; en=0 freezes every register, so level outputs simply persist.
module vga_timing import vga_pkg::*; #(
    parameter int   H_ACTIVE    = VGA_H_ACTIVE,
    parameter int   H_FP        = VGA_H_FP,
    parameter int   H_SYNC      = VGA_H_SYNC,
    parameter int   H_BP        = VGA_H_BP,
    parameter int   V_ACTIVE    = VGA_V_ACTIVE,
    parameter int   V_FP        = VGA_V_FP,
    parameter int   V_SYNC      = VGA_V_SYNC,
    parameter int   V_BP        = VGA_V_BP,
    parameter logic SYNC_ACTIVE = VGA_SYNC_ACTIVE,
    parameter int   FRAME_BITS  = VGA_FRAME_BITS
) (
    input  logic clk,
    input  logic rst_n,
    vga_timing_if.master vif
);
    localparam int H_TOTAL = vga_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = vga_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int XB      = $clog2(H_TOTAL);
    localparam int YB      = $clog2(V_TOTAL);

    logic [XB-1:0] h_cnt;
    logic [YB-1:0] v_cnt;
    logic          h_wrap, v_wrap;
    logic          h_sync_nxt, h_act_nxt, h_zero_nxt;
    logic          v_sync_nxt, v_act_nxt, v_zero_nxt;

    vga_axis_counter #(
        .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .W(XB)
    ) u_h (
        .clk(clk), .rst_n(rst_n), .step(vif.en),
        .cnt(h_cnt), .wrap(h_wrap),
        .sync_nxt(h_sync_nxt), .active_nxt(h_act_nxt), .zero_nxt(h_zero_nxt)
    );

    // The vertical axis moves only when a line finishes.
    vga_axis_counter #(
        .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .W(YB)
    ) u_v (
        .clk(clk), .rst_n(rst_n), .step(h_wrap),
        .cnt(v_cnt), .wrap(v_wrap),
        .sync_nxt(v_sync_nxt), .active_nxt(v_act_nxt), .zero_nxt(v_zero_nxt)
    );

    logic [FRAME_BITS-1:0] frame_count_q, frame_count_d;
    logic hsync_q, hsync_d;
    logic vsync_q, vsync_d;
    logic de_q, de_d;
    logic line_start_q, line_start_d;
    logic frame_start_q, frame_start_d;

    // Output levels for the next counter position, so they land in the same cycle as it.
    always_comb begin
        frame_count_d = frame_count_q;
        if (v_wrap) frame_count_d = frame_count_q + FRAME_BITS'(1);
        hsync_d       = h_sync_nxt ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        vsync_d       = v_sync_nxt ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        de_d          = h_act_nxt & v_act_nxt;
        line_start_d  = h_zero_nxt;
        frame_start_d = h_zero_nxt & v_zero_nxt;
    end

    // Output registers; reset lands on pixel (0,0) with syncs inactive.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_count_q <= '0;
            hsync_q       <= ~SYNC_ACTIVE;
            vsync_q       <= ~SYNC_ACTIVE;
            de_q          <= 1'b1;
            line_start_q  <= 1'b1;
            frame_start_q <= 1'b1;
        end else begin
            frame_count_q <= frame_count_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            de_q          <= de_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

`ifdef VGA_TIMING_PIPE_EN
    logic hsync_p_q, hsync_p_d;
    logic vsync_p_q, vsync_p_d;
    logic de_p_q, de_p_d;

    // Extra stage for renderers whose colour arrives one pixel late; it only moves with en.
    always_comb begin
        hsync_p_d = hsync_p_q;
        vsync_p_d = vsync_p_q;
        de_p_d    = de_p_q;
        if (vif.en) begin
            hsync_p_d = hsync_q;
            vsync_p_d = vsync_q;
            de_p_d    = de_q;
        end
    end

    // Delay registers start inactive so nothing visible leaks out before the first pixel.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hsync_p_q <= ~SYNC_ACTIVE;
            vsync_p_q <= ~SYNC_ACTIVE;
            de_p_q    <= 1'b0;
        end else begin
            hsync_p_q <= hsync_p_d;
            vsync_p_q <= vsync_p_d;
            de_p_q    <= de_p_d;
        end
    end

    assign vif.hsync = hsync_p_q;
    assign vif.vsync = vsync_p_q;
    assign vif.de    = de_p_q;
`else
    assign vif.hsync = hsync_q;
    assign vif.vsync = vsync_q;
    assign vif.de    = de_q;
`endif

    assign vif.pixel_x     = h_cnt;
    assign vif.pixel_y     = v_cnt;
    assign vif.line_start  = line_start_q;
    assign vif.frame_start = frame_start_q;
    assign vif.frame_count = frame_count_q;

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: default 640x480 instance plus a shrunken-raster instance with positive syncs.
// Latency: expectations derive from a linear count of en cycles since reset.
// Backpressure: en is randomised, alternated and held to exercise the hold behaviour.
module tb_vga_timing;
    localparam int SH_A = 16, SH_F = 2, SH_S = 3, SH_B = 3;
    localparam int SV_A = 6,  SV_F = 1, SV_S = 2, SV_B = 2;
    localparam int SHT  = SH_A + SH_F + SH_S + SH_B;   // 24
    localparam int SVT  = SV_A + SV_F + SV_S + SV_B;   // 11

    logic clk = 1'b0;
    logic rst_n;
    logic en;
    logic chk_on;
    int   cnt_total = 0;
    int   cnt_bad   = 0;
    int   pos_d, pos_s;

    always #5 clk = ~clk;

    vga_timing_if #(.XB(10), .YB(10), .FB(5)) if_d();
    vga_timing_if #(.XB(5),  .YB(4),  .FB(5)) if_s();

    assign if_d.en = en;
    assign if_s.en = en;

    vga_timing dut_d (.clk(clk), .rst_n(rst_n), .vif(if_d.master));

    vga_timing #(
        .H_ACTIVE(SH_A), .H_FP(SH_F), .H_SYNC(SH_S), .H_BP(SH_B),
        .V_ACTIVE(SV_A), .V_FP(SV_F), .V_SYNC(SV_S), .V_BP(SV_B),
        .SYNC_ACTIVE(1'b1), .FRAME_BITS(5)
    ) dut_s (.clk(clk), .rst_n(rst_n), .vif(if_s.master));

    // Reference position: number of en cycles since the last reset edge.
    always @(posedge clk) begin
        if (!rst_n) begin
            pos_d <= 0;
            pos_s <= 0;
        end else if (en) begin
            pos_d <= pos_d + 1;
            pos_s <= pos_s + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        cnt_total++;
        if (act !== exp) begin
            cnt_bad++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Expected outputs from the raster rules, given a linear position.
    task automatic model(input int pos, input int ha, input int hf, input int hs, input int hb,
                         input int va, input int vf, input int vs, input int vb, input int sa,
                         output int x, output int y, output int fc, output int ehs,
                         output int evs, output int ede, output int els, output int efs);
        int ht, vt, p, sx, sy;
        ht  = ha + hf + hs + hb;
        vt  = va + vf + vs + vb;
        x   = pos % ht;
        y   = (pos / ht) % vt;
        fc  = (pos / (ht * vt)) % 32;
        els = (x == 0) ? 1 : 0;
        efs = (x == 0 && y == 0) ? 1 : 0;
`ifdef VGA_TIMING_PIPE_EN
        p = pos - 1;
`else
        p = pos;
`endif
        if (p < 0) begin
            ehs = 1 - sa;
            evs = 1 - sa;
            ede = 0;
        end else begin
            sx  = p % ht;
            sy  = (p / ht) % vt;
            ehs = (sx >= ha + hf && sx < ha + hf + hs) ? sa : 1 - sa;
            evs = (sy >= va + vf && sy < va + vf + vs) ? sa : 1 - sa;
            ede = (sx < ha && sy < va) ? 1 : 0;
        end
    endtask

    int ex, ey, ef, eh, ev, ed, el, es;

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (chk_on) begin
            model(pos_d, 640, 16, 96, 48, 480, 10, 2, 33, 0, ex, ey, ef, eh, ev, ed, el, es);
            check("d.pixel_x", 32'(if_d.pixel_x), ex);
            check("d.pixel_y", 32'(if_d.pixel_y), ey);
            check("d.frame_count", 32'(if_d.frame_count), ef);
            check("d.hsync", 32'(if_d.hsync), eh);
            check("d.vsync", 32'(if_d.vsync), ev);
            check("d.de", 32'(if_d.de), ed);
            check("d.line_start", 32'(if_d.line_start), el);
            check("d.frame_start", 32'(if_d.frame_start), es);
            model(pos_s, SH_A, SH_F, SH_S, SH_B, SV_A, SV_F, SV_S, SV_B, 1, ex, ey, ef, eh, ev, ed, el, es);
            check("s.pixel_x", 32'(if_s.pixel_x), ex);
            check("s.pixel_y", 32'(if_s.pixel_y), ey);
            check("s.frame_count", 32'(if_s.frame_count), ef);
            check("s.hsync", 32'(if_s.hsync), eh);
            check("s.vsync", 32'(if_s.vsync), ev);
            check("s.de", 32'(if_s.de), ed);
            check("s.line_start", 32'(if_s.line_start), el);
            check("s.frame_start", 32'(if_s.frame_start), es);
        end
    end

    task automatic wait_dx(input int tgt);
        int n;
        n = 0;
        while (32'(if_d.pixel_x) != tgt && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) begin
            cnt_total++;
            cnt_bad++;
            $display("FAIL wait_dx: pixel_x %0d never reached, last %0d", tgt, if_d.pixel_x);
        end
    endtask

    task automatic wait_s(input int tx, input int ty, input int tf);
        int n;
        n = 0;
        while (!(32'(if_s.pixel_x) == tx && 32'(if_s.pixel_y) == ty && 32'(if_s.frame_count) == tf)
               && n < 12000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 12000) begin
            cnt_total++;
            cnt_bad++;
            $display("FAIL wait_s: position %0d,%0d frame %0d never reached", tx, ty, tf);
        end
    endtask

    initial begin
        int c, t0, t1;
        logic [4:0] f0;

        rst_n  = 1'b0;
        en     = 1'b0;
        chk_on = 1'b0;
        repeat (3) @(negedge clk);
        chk_on = 1'b1;

        // Reset must win over en; state seen at release is pixel (0,0).
        en = 1'b1;
        @(negedge clk);
        check("rst.x", 32'(if_d.pixel_x), 0);
        check("rst.y", 32'(if_d.pixel_y), 0);
        check("rst.frame_count", 32'(if_d.frame_count), 0);
        check("rst.frame_start", 32'(if_d.frame_start), 1);
        check("rst.hsync", 32'(if_d.hsync), 1);
        check("rst.vsync", 32'(if_d.vsync), 1);
        check("rst.s_hsync", 32'(if_s.hsync), 0);
`ifdef VGA_TIMING_PIPE_EN
        check("rst.de", 32'(if_d.de), 0);
`else
        check("rst.de", 32'(if_d.de), 1);
`endif
        rst_n = 1'b1;

        // One free-running line on the default raster.
`ifdef VGA_TIMING_PIPE_EN
        wait_dx(640); check("line.de@640", 32'(if_d.de), 1);
        wait_dx(641); check("line.de@641", 32'(if_d.de), 0);
        wait_dx(656); check("line.hs@656", 32'(if_d.hsync), 1);
        wait_dx(657); check("line.hs@657", 32'(if_d.hsync), 0);
`else
        wait_dx(639); check("line.de@639", 32'(if_d.de), 1);
        wait_dx(640); check("line.de@640", 32'(if_d.de), 0);
        wait_dx(655); check("line.hs@655", 32'(if_d.hsync), 1);
        wait_dx(656); check("line.hs@656", 32'(if_d.hsync), 0);
        wait_dx(751); check("line.hs@751", 32'(if_d.hsync), 0);
        wait_dx(752); check("line.hs@752", 32'(if_d.hsync), 1);
`endif

        // Random pixel-rate enable.
        repeat (3000) begin
            @(negedge clk);
            en = ($urandom_range(0, 3) != 0);
        end

        // Alternating enable: a small-raster frame must take twice its pixel count in clocks.
        c  = 0;
        t0 = -1;
        t1 = -1;
        f0 = if_s.frame_count;
        while (t1 < 0 && c < 3000) begin
            @(negedge clk);
            en = ~en;
            c++;
            if (if_s.frame_count != f0) begin
                if (t0 < 0) t0 = c;
                else        t1 = c;
                f0 = if_s.frame_count;
            end
        end
        check("alt.frame_period", t1 - t0, 2 * SHT * SVT);

        // Reset mid-frame while both syncs are asserted.
        en = 1'b1;
        wait_s(20, 7, 7);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst.x", 32'(if_s.pixel_x), 0);
        check("midrst.y", 32'(if_s.pixel_y), 0);
        check("midrst.frame_count", 32'(if_s.frame_count), 0);
        check("midrst.hsync", 32'(if_s.hsync), 0);
        check("midrst.vsync", 32'(if_s.vsync), 0);
        rst_n = 1'b1;

        // Frame wrap and frame_count roll-over.
        wait_s(SHT - 1, SVT - 1, 0);
        @(negedge clk);
        check("wrap.x", 32'(if_s.pixel_x), 0);
        check("wrap.y", 32'(if_s.pixel_y), 0);
        check("wrap.frame_count", 32'(if_s.frame_count), 1);
        wait_s(SHT - 1, SVT - 1, 31);
        @(negedge clk);
        check("roll.frame_count", 32'(if_s.frame_count), 0);
        check("roll.frame_start", 32'(if_s.frame_start), 1);

        chk_on = 1'b0;
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", cnt_total, cnt_bad);
        $finish;
    end

endmodule

// File: doc/vga_timing.md
VGA_TIMING -- requirements
Module: vga_timing

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640: visible pixels per line.
REQ-002 SHALL have parameters H_FP / H_SYNC / H_BP, defaults 16 / 96 / 48: horizontal porch and sync widths in pixels.
REQ-003 SHALL have parameter V_ACTIVE, default 480: visible lines per frame.
REQ-004 SHALL have parameters V_FP / V_SYNC / V_BP, defaults 10 / 2 / 33: vertical porch and sync widths in lines.
REQ-005 SHALL have parameter SYNC_ACTIVE, default 0: logic level of an asserted hsync/vsync.
REQ-006 SHALL have parameter FRAME_BITS, default 5: width of frame_count.
REQ-007 SHALL have clk, input, 1: rising-edge clock.
REQ-008 SHALL have rst_n, input, 1: synchronous, active-low reset.
REQ-009 SHALL have en, input, 1: pixel-rate enable; state advances only on cycles with en=1.
REQ-010 SHALL have pixel_x, output, XB=$clog2(H_TOTAL): current column.
REQ-011 SHALL have pixel_y, output, YB=$clog2(V_TOTAL): current line.
REQ-012 SHALL have hsync, output, 1: horizontal sync.
REQ-013 SHALL have vsync, output, 1: vertical sync.
REQ-014 SHALL have de, output, 1: display enable.
REQ-015 SHALL have line_start, output, 1: high while pixel_x==0.
REQ-016 SHALL have frame_start, output, 1: high while pixel_x==0 and pixel_y==0.
REQ-017 SHALL have frame_count, output, FRAME_BITS: completed-frame counter for animation phase selection.

Function
REQ-018 SHALL define H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP (800) and V_TOTAL likewise (525).
REQ-019 SHALL increment pixel_x on each en=1 cycle; pixel_x==H_TOTAL-1 wraps to 0 and steps pixel_y.
REQ-020 SHALL wrap pixel_y from V_TOTAL-1 to 0 together with pixel_x, and increment frame_count modulo 2^FRAME_BITS in the same cycle.
REQ-021 SHALL hold all registers unchanged on cycles with en=0; level outputs therefore persist and consumers qualify pulses with en.
REQ-022 SHALL assert hsync (==SYNC_ACTIVE) iff H_ACTIVE+H_FP <= pixel_x < H_ACTIVE+H_FP+H_SYNC (656..751).
REQ-023 SHALL assert vsync iff V_ACTIVE+V_FP <= pixel_y < V_ACTIVE+V_FP+V_SYNC (490..491).
REQ-024 SHALL drive de=1 iff pixel_x<H_ACTIVE and pixel_y<V_ACTIVE.
REQ-025 SHALL register every output; all outputs in a given cycle describe the same (pixel_x, pixel_y) position, with zero combinational path from en to outputs.
REQ-026 SHALL give sync/de registers their next value from the next counter position, not from the current one, to keep the alignment required by REQ-025.

Reset
REQ-027 SHALL, on the clock edge with rst_n=0, set pixel_x=0, pixel_y=0, frame_count=0, de=1, line_start=1, frame_start=1, and hsync=vsync=!SYNC_ACTIVE, regardless of en.
REQ-028 SHALL let reset mid-frame abandon the current position with no partial sync pulse carried over.

Configuration
REQ-029 SHALL, with macro VGA_TIMING_PIPE_EN defined, delay hsync, vsync and de by exactly one en=1 cycle relative to pixel_x/pixel_y, to match a renderer that registers its colour one pixel later. The delay stage SHALL reset to inactive/0.
REQ-030 SHALL, without VGA_TIMING_PIPE_EN, keep all outputs aligned as in REQ-025; the port list is identical in both builds.

Structure
REQ-031 SHALL take the default timing constants, the H_TOTAL/V_TOTAL derivation and the sync level constants from shared package vga_pkg, which the renderer also uses.
REQ-032 SHALL instantiate sub-module vga_axis_counter (wrap counter with sync-window and active-window compare) twice: horizontal, and vertical stepped by the horizontal wrap.

Verification
REQ-033 SHALL cover: release reset with en=1 -> first cycle x=0, y=0, de=1, frame_start=1, hsync=vsync=1.
REQ-034 SHALL cover: free-run one line -> hsync=1 at x=655, 0 for x=656..751, 1 at x=752; de=0 from x=640.
REQ-035 SHALL cover: run to x=799, y=524 -> next cycle x=0, y=0, frame_count 0->1; after 32 frames frame_count wraps 31->0.
REQ-036 SHALL cover: en alternating 1/0 -> each position held 2 cycles; one frame takes 840000 clk cycles (420000 with en=1).
REQ-037 SHALL cover: rst_n=0 for one cycle at x=300, y=200, frame_count=7 -> next cycle x=0, y=0, frame_count=0, syncs inactive.
REQ-038 SHALL cover: with VGA_TIMING_PIPE_EN defined -> hsync first 0 when pixel_x=657 and de first 0 when pixel_x=641.
